// File: rtl/neumaier_chunk_accumulator.sv
// Realigns chunk tags with the adder-tree latency and sums the tree's partial sums into vector totals.
// Total is valid TREE_LATENCY+1 cycles after the last chunk enters. If the output register is still held, a new total is dropped and overrun is flagged.
module neumaier_chunk_accumulator #(
   parameter int IN_WIDTH     = 13,
   parameter int OUT_WIDTH    = 16,
   parameter int MAX_CHUNKS   = 16,
   parameter int TREE_LATENCY = 4,
   localparam int ACC_WIDTH   = IN_WIDTH + $clog2(MAX_CHUNKS),
   localparam int CNT_WIDTH   = $clog2(MAX_CHUNKS + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 chunk_valid_i,
   input  logic                 chunk_last_i,
   input  logic [IN_WIDTH-1:0]  sum_i,
   input  logic                 clear_flags_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [OUT_WIDTH-1:0] out_sum_o,
   output logic [CNT_WIDTH-1:0] out_chunks_o,
   output logic                 out_sat_o,
   output logic                 busy_o,
   output logic                 overrun_o,
   output logic                 len_err_o
);

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      (ACC_WIDTH'(1) << (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   state_t                       state_q;
   logic [TREE_LATENCY-1:0]      tag_vld_q;
   logic [TREE_LATENCY-1:0]      tag_last_q;
   logic signed [ACC_WIDTH-1:0]  acc_q;
   logic [CNT_WIDTH-1:0]         cnt_q;

   logic                         d_valid;
   logic                         d_last;
   logic signed [ACC_WIDTH-1:0]  sum_ext;
   logic signed [ACC_WIDTH-1:0]  acc_base;
   logic signed [ACC_WIDTH-1:0]  acc_next;
   logic [CNT_WIDTH-1:0]         cnt_base;
   logic [CNT_WIDTH-1:0]         cnt_next;
   logic                         cnt_full;
   logic                         emit;
   logic                         force_close;
   logic                         load_ok;
   logic                         sat_hi;
   logic                         sat_lo;
   logic [OUT_WIDTH-1:0]         sat_val;

   assign d_valid  = tag_vld_q[TREE_LATENCY-1];
   assign d_last   = tag_last_q[TREE_LATENCY-1];
   assign sum_ext  = ACC_WIDTH'($signed(sum_i));

   // In IDLE the running sum restarts from zero, so one adder covers both states.
   assign acc_base = (state_q == ACCUM) ? acc_q : '0;
   assign cnt_base = (state_q == ACCUM) ? cnt_q : '0;
   assign acc_next = acc_base + sum_ext;
   assign cnt_next = cnt_base + CNT_WIDTH'(1);
   assign cnt_full = (cnt_next == CNT_WIDTH'(MAX_CHUNKS));

   assign emit        = d_valid && (d_last || cnt_full);
   assign force_close = d_valid && !d_last && cnt_full;
   assign load_ok     = !out_valid_o || out_ready_i;

   assign sat_hi  = (acc_next > SAT_MAX);
   assign sat_lo  = (acc_next < SAT_MIN);
   assign sat_val = sat_hi ? SAT_MAX[OUT_WIDTH-1:0] :
                    sat_lo ? SAT_MIN[OUT_WIDTH-1:0] :
                             acc_next[OUT_WIDTH-1:0];

   assign busy_o = (state_q == ACCUM) || (|tag_vld_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         tag_vld_q    <= '0;
         tag_last_q   <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         out_valid_o  <= 1'b0;
         out_sum_o    <= '0;
         out_chunks_o <= '0;
         out_sat_o    <= 1'b0;
         overrun_o    <= 1'b0;
         len_err_o    <= 1'b0;
      end else begin
         // The tree never stalls, so the tag line shifts every cycle.
         tag_vld_q  <= (tag_vld_q << 1) | TREE_LATENCY'(chunk_valid_i);
         tag_last_q <= (tag_last_q << 1) | TREE_LATENCY'(chunk_valid_i & chunk_last_i);

         if (d_valid) begin
            acc_q   <= acc_next;
            cnt_q   <= cnt_next;
            state_q <= emit ? IDLE : ACCUM;
         end

         if (emit && load_ok) begin
            out_valid_o  <= 1'b1;
            out_sum_o    <= sat_val;
            out_chunks_o <= cnt_next;
            out_sat_o    <= sat_hi || sat_lo;
         end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
         end

         overrun_o <= (overrun_o && !clear_flags_i) || (emit && !load_ok);
         len_err_o <= (len_err_o && !clear_flags_i) || force_close;
      end
   end

endmodule

// File: doc/neumaier_chunk_accumulator.md
Name: neumaier_chunk_accumulator

Overview:
- Downstream consumer of the Neumaier adder tree.
- A long dot product is split into chunks of ELEMS_COUNT elements. Each chunk passes through the tree and produces one signed partial sum.
- This block realigns the chunk valid/last tags with the tree's fixed pipeline latency and accumulates the partial sums of one vector.
- It presents each finished vector total through a valid/ready output register, with saturation and sticky error flags.

Parameters:
- IN_WIDTH, 13, width of tree partial sum (tree SUM_WIDTH_O).
- OUT_WIDTH, 16, width of emitted total; saturating.
- MAX_CHUNKS, 16, maximum chunks per vector.
- TREE_LATENCY, 4, cycles from tree input vector to matching o_sum; must be ≥1.
- ACC_WIDTH, IN_WIDTH+$clog2(MAX_CHUNKS), localparam, internal accumulator width.
- CNT_WIDTH, $clog2(MAX_CHUNKS+1), localparam.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- chunk_valid_i  in  1  a chunk vector is driven into the tree this cycle.
- chunk_last_i  in  1  that chunk is the final one of its vector; qualified by chunk_valid_i.
- sum_i  in  IN_WIDTH  signed tree o_sum.
- clear_flags_i  in  1  clears sticky flags.
- out_valid_o  out  1  total available.
- out_ready_i  in  1  consumer accepts total.
- out_sum_o  out  OUT_WIDTH  signed saturated vector total.
- out_chunks_o  out  CNT_WIDTH  number of chunks in the total.
- out_sat_o  out  1  total was clipped.
- busy_o  out  1  partial vector in progress, or tags in flight.
- overrun_o  out  1  sticky: a total was dropped.
- len_err_o  out  1  sticky: MAX_CHUNKS reached without last.

Behaviour:
- Clocking/reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all outputs 0; tag pipeline cleared; FSM to IDLE; accumulator 0.
- Reset mid-vector discards the partial sum and all in-flight tags. A sum_i arriving after reset is ignored because its tag was cleared.
- Tag pipeline: TREE_LATENCY-deep shift register of {valid, last}. Its output {d_valid, d_last} is coincident with the matching sum_i. The tree cannot stall, so the tags are never held.
- Sign extension: sum_i is sign-extended to ACC_WIDTH. Addition is two's complement. No wrap is possible within MAX_CHUNKS.
- FSM state IDLE (no partial):
  - On d_valid: acc←sext(sum_i), cnt←1, go to ACCUM.
  - If d_last is also set, emit and stay in IDLE.
- FSM state ACCUM:
  - On d_valid: acc←acc+sext(sum_i), cnt←cnt+1.
  - If d_last: emit and go to IDLE.
  - Else if cnt+1==MAX_CHUNKS: emit, set len_err_o, go to IDLE (forced close).
  - No d_valid: hold.
- Emit value: total = acc_next, where acc_next is the value including this cycle's sum_i.
  - Saturate to OUT_WIDTH: clip to max positive or min negative; out_sat_o=1 iff clipped.
  - out_chunks_o = cnt_next.
- Output register and handshake:
  - An emit loads the register and sets out_valid_o=1 next cycle, provided out_valid_o==0, or out_valid_o && out_ready_i this cycle (simultaneous accept and load allowed).
  - Otherwise the new total is dropped, overrun_o is set, and the held total is unchanged.
  - While out_valid_o=1, out_sum_o, out_chunks_o and out_sat_o are stable until accepted.
  - out_valid_o falls the cycle after out_valid_o && out_ready_i with no new emit.
- Latency: last chunk at cycle t on chunk_valid_i → out_valid_o high at t+TREE_LATENCY+1.
- busy_o = FSM in ACCUM OR any tag valid in the pipeline.
- Sticky flags:
  - clear_flags_i clears overrun_o and len_err_o next cycle.
  - A set event in the same cycle as clear wins (flag remains 1).
- Ignored inputs: chunk_last_i without chunk_valid_i is ignored. sum_i is ignored when d_valid=0.

Test Plan:
- Single-chunk vector: valid+last with sum_i=37 at the aligned cycle → out_sum_o=37, out_chunks_o=1, out_valid_o at t+5 (default latency); ready=1 drops valid next cycle.
- Four-chunk vector, sums 100, -250, 7, 3 on consecutive cycles → out_sum_o=-140, out_chunks_o=4, out_sat_o=0.
- Saturation: 16 chunks of +4095 with last on 16th → total 65520 clips to 32767, out_sat_o=1; 16 chunks of -4096 → -32768, out_sat_o=1.
- Back-pressure: out_ready_i=0; vector A (sum 5) then vector B (sum 9) completes → out_sum_o stays 5, overrun_o=1. Then ready=1 with vector C completing in the same cycle → C loaded seamlessly, no overrun. clear_flags_i → overrun_o=0.
- Length error: 16 valid chunks of 1 without last → emit out_sum_o=16, out_chunks_o=16, len_err_o=1. The 17th chunk starts a new vector.
- Reset mid-vector: 2 chunks accumulated plus 2 in flight, assert rst_i one cycle → all outputs 0, in-flight sums not accumulated. A subsequent vector of sums 1 and 2 → out_sum_o=3.
